// File: rtl/sample_sequencer_if.sv
// sample_sequencer_if
//   Bundles the sequencer's control, ADC, filter and DAC signals.
//   master : the sequencer itself (drives start pulses, data and status).
//   slave  : the surrounding top level / SPI engines / filter bank.
//
//   enable_i      run request
//   clear_i       synchronous clear of sticky flags and sample counter
//   adc_start_o   one-cycle ADC start pulse
//   adc_idle_i    ADC reader idle
//   adc_data_i    signed ADC sample
//   filt_stb_o    one-cycle filter enable strobe
//   filt_in_o     registered ADC sample to the filters
//   filt_data_i   signed filter output
//   dac_start_o   one-cycle DAC start pulse
//   dac_idle_i    DAC writer idle
//   dac_data_o    registered DAC sample
//   busy_o        sequencer not idle
//   overrun_o     sticky: period tick arrived while busy
//   timeout_o     sticky: a wait state timed out
//   sample_cnt_o  completed samples (wrapping)
interface sample_sequencer_if;
    logic        enable_i;
    logic        clear_i;
    logic        adc_start_o;
    logic        adc_idle_i;
    logic [15:0] adc_data_i;
    logic        filt_stb_o;
    logic [15:0] filt_in_o;
    logic [15:0] filt_data_i;
    logic        dac_start_o;
    logic        dac_idle_i;
    logic [15:0] dac_data_o;
    logic        busy_o;
    logic        overrun_o;
    logic        timeout_o;
    logic [15:0] sample_cnt_o;

    modport master (
        input  enable_i, clear_i, adc_idle_i, adc_data_i, filt_data_i, dac_idle_i,
        output adc_start_o, filt_stb_o, filt_in_o, dac_start_o, dac_data_o,
               busy_o, overrun_o, timeout_o, sample_cnt_o
    );

    modport slave (
        output enable_i, clear_i, adc_idle_i, adc_data_i, filt_data_i, dac_idle_i,
        input  adc_start_o, filt_stb_o, filt_in_o, dac_start_o, dac_data_o,
               busy_o, overrun_o, timeout_o, sample_cnt_o
    );
endinterface

// File: rtl/sample_sequencer.sv
// sample_sequencer
//   Sample-rate scheduler for the ADC -> filter -> DAC path. An internal
//   period counter produces one tick every SAMPLE_DIV cycles; each accepted
//   tick runs one sample strictly in order: ADC conversion, filter strobe,
//   DAC write. Ticks arriving while a sample is in flight are dropped and
//   flagged as overrun; SPI engines that never complete are aborted after
//   TIMEOUT cycles and flagged.
//
// Parameters
//   SAMPLE_DIV  clk_i cycles per sample period (>= 8)
//   FILT_LAT    cycles from filt_stb_o to valid filt_data_i (>= 1)
//   TIMEOUT     max cycles spent in a wait state before abort
//
// Ports
//   clk_i     system clock
//   reset_ni  asynchronous active-low reset
//   bus       sample_sequencer_if.master (see interface file for signals)
//
// All outputs are registered; nothing combinational from inputs to outputs.
module sample_sequencer #(
    parameter int SAMPLE_DIV = 50,
    parameter int FILT_LAT   = 1,
    parameter int TIMEOUT    = 4095
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    sample_sequencer_if.master    bus
);

    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int LAT_W  = $clog2(FILT_LAT + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADC_START,
        S_ADC_WAIT,
        S_FILT,
        S_FILT_WAIT,
        S_DAC_START,
        S_DAC_WAIT
    } state_e;

    // ------------------------------------------------------------------
    // Period counter: free-running, independent of enable_i and the FSM.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick;

    always_comb begin
        tick      = (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) div_cnt_q <= '0;
        else           div_cnt_q <= div_cnt_d;
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with its datapath and status registers.
    // ------------------------------------------------------------------
    state_e            state_q;
    logic              seen_busy_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [LAT_W-1:0]  lat_q;
    logic              adc_start_q;
    logic              filt_stb_q;
    logic              dac_start_q;
    logic [15:0]       filt_in_q;
    logic [15:0]       dac_data_q;
    logic              busy_q;
    logic              overrun_q;
    logic              timeout_q;
    logic [15:0]       sample_cnt_q;

    // The wait counter is zero in the first wait cycle, so the cycle in
    // which it holds TIMEOUT-1 is the TIMEOUT-th cycle spent waiting: the
    // count would reach TIMEOUT on the next edge, and we abort instead.
    logic adc_done, dac_done, wait_expired;

    always_comb begin
        adc_done     = seen_busy_q && bus.adc_idle_i;
        dac_done     = seen_busy_q && bus.dac_idle_i;
        wait_expired = (wait_cnt_q == WAIT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            seen_busy_q  <= 1'b0;
            wait_cnt_q   <= '0;
            lat_q        <= '0;
            adc_start_q  <= 1'b0;
            filt_stb_q   <= 1'b0;
            dac_start_q  <= 1'b0;
            filt_in_q    <= '0;
            dac_data_q   <= '0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            // Pulses default low; they are raised on the transition into
            // the state they belong to so they line up with that state.
            adc_start_q <= 1'b0;
            filt_stb_q  <= 1'b0;
            dac_start_q <= 1'b0;

            // Clear first; any set below in the same cycle overrides it.
            if (bus.clear_i) begin
                overrun_q    <= 1'b0;
                timeout_q    <= 1'b0;
                sample_cnt_q <= '0;
            end

            // Any tick outside IDLE is dropped, including one landing on
            // the final DAC_WAIT cycle or on a timeout abort.
            if (tick && (state_q != S_IDLE))
                overrun_q <= 1'b1;

            unique case (state_q)
                S_IDLE: begin
                    if (tick && bus.enable_i) begin
                        state_q     <= S_ADC_START;
                        adc_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end

                S_ADC_START: begin
                    seen_busy_q <= 1'b0;
                    wait_cnt_q  <= '0;
                    state_q     <= S_ADC_WAIT;
                end

                S_ADC_WAIT: begin
                    if (adc_done) begin
                        filt_in_q  <= bus.adc_data_i;
                        filt_stb_q <= 1'b1;
                        state_q    <= S_FILT;
                    end else if (wait_expired) begin
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                        if (!bus.adc_idle_i) seen_busy_q <= 1'b1;
                    end
                end

                S_FILT: begin
                    lat_q   <= LAT_W'(FILT_LAT);
                    state_q <= S_FILT_WAIT;
                end

                // Spends exactly FILT_LAT cycles here; the filter output is
                // captured on the cycle the latency counter runs out.
                S_FILT_WAIT: begin
                    lat_q <= lat_q - LAT_W'(1);
                    if (lat_q == LAT_W'(1)) begin
                        dac_data_q  <= bus.filt_data_i;
                        dac_start_q <= 1'b1;
                        state_q     <= S_DAC_START;
                    end
                end

                S_DAC_START: begin
                    seen_busy_q <= 1'b0;
                    wait_cnt_q  <= '0;
                    state_q     <= S_DAC_WAIT;
                end

                S_DAC_WAIT: begin
                    if (dac_done) begin
                        // A coincident clear restarts the count from zero
                        // but still credits this completed sample.
                        sample_cnt_q <= (bus.clear_i ? 16'd0 : sample_cnt_q) + 16'd1;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end else if (wait_expired) begin
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                        if (!bus.dac_idle_i) seen_busy_q <= 1'b1;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.adc_start_o  = adc_start_q;
    assign bus.filt_stb_o   = filt_stb_q;
    assign bus.filt_in_o    = filt_in_q;
    assign bus.dac_start_o  = dac_start_q;
    assign bus.dac_data_o   = dac_data_q;
    assign bus.busy_o       = busy_q;
    assign bus.overrun_o    = overrun_q;
    assign bus.timeout_o    = timeout_q;
    assign bus.sample_cnt_o = sample_cnt_q;

endmodule

// File: tb/tb_sample_sequencer.sv
module tb_sample_sequencer;
    localparam int DIV = 40;
    localparam int LAT = 4;
    localparam int TMO = 100;
    localparam int INF = 1 << 30;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sample_sequencer_if bus ();

    sample_sequencer #(.SAMPLE_DIV(DIV), .FILT_LAT(LAT), .TIMEOUT(TMO)) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus.master)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: the sequencer is busy for cycles in
    // [start_cyc, free_cyc); flags/counter hold the values expected this cycle.
    int          n, pcnt;
    int          start_cyc, free_cyc, fstb_cyc, to_cyc, f_cyc;
    logic        exp_ov, exp_to;
    logic [15:0] exp_cnt, adc_v, f_val;
    int          adc_left, dac_left;
    int          adc_min = 2, adc_max = 20;
    bit          en_cmd, hang_next, dir_next, drop_en_req;
    bit          clear_now, clear_on_tick, saw_fstb;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_adc_start"},  bus.adc_start_o,  0);
        chk({tag, "_filt_stb"},   bus.filt_stb_o,   0);
        chk({tag, "_dac_start"},  bus.dac_start_o,  0);
        chk({tag, "_filt_in"},    bus.filt_in_o,    0);
        chk({tag, "_dac_data"},   bus.dac_data_o,   0);
        chk({tag, "_busy"},       bus.busy_o,       0);
        chk({tag, "_overrun"},    bus.overrun_o,    0);
        chk({tag, "_timeout"},    bus.timeout_o,    0);
        chk({tag, "_sample_cnt"}, bus.sample_cnt_o, 0);
    endtask

    task automatic model_reset();
        start_cyc = -1; free_cyc = -1; fstb_cyc = -1; to_cyc = -1; f_cyc = -1;
        exp_ov = 0; exp_to = 0; exp_cnt = 0;
        adc_left = 0; dac_left = 0;
        bus.adc_idle_i = 1'b1;
        bus.dac_idle_i = 1'b1;
        sb.delete();
    endtask

    // Scoreboard monitor: every DAC start must match the oldest expected sample.
    always @(negedge clk) begin
        if (rst_n && bus.dac_start_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dac_unexpected cycle %0d: got dac_start with data %0h, expected none",
                         cyc, bus.dac_data_o);
            end else begin
                mon_e = sb.pop_front();
                chk("dac_data",  bus.dac_data_o, mon_e.data);
                chk("dac_cycle", cyc,            mon_e.cyc);
            end
        end
    end

    // One clock cycle: check outputs against the model, then play the
    // ADC/filter/DAC environment and advance the model.
    task automatic step(input bit do_rst = 1'b0);
        bit   tick, busy_n, inc, set_to, ov_set;
        exp_t e;
        @(negedge clk);
        n      = cyc;
        busy_n = (n >= start_cyc) && (n < free_cyc);
        chk("adc_start",  bus.adc_start_o,  32'(n == start_cyc));
        chk("filt_stb",   bus.filt_stb_o,   32'(n == fstb_cyc));
        chk("busy",       bus.busy_o,       32'(busy_n));
        chk("overrun",    bus.overrun_o,    exp_ov);
        chk("timeout",    bus.timeout_o,    exp_to);
        chk("sample_cnt", bus.sample_cnt_o, exp_cnt);

        if (do_rst) begin
            #1 rst_n = 1'b0;
            #1 chk_zero("rst_async");
            #2 rst_n = 1'b1;
            model_reset();
            pcnt = 0;
        end

        busy_n = (n >= start_cyc) && (n < free_cyc);
        tick   = (pcnt == DIV - 1);
        inc    = 0;
        set_to = 0;
        bus.enable_i = en_cmd;

        // DAC writer
        if (dac_left > 0) begin
            dac_left--;
            if (drop_en_req) begin
                en_cmd = 0; bus.enable_i = 1'b0; drop_en_req = 0;
            end
            if (dac_left == 0) begin
                bus.dac_idle_i = 1'b1;
                free_cyc = n + 1;
                inc = 1;
            end
        end
        if (bus.dac_start_o) begin
            bus.dac_idle_i = 1'b0;
            dac_left = $urandom_range(2, 12);
        end

        // ADC reader
        if (adc_left > 0) begin
            adc_left--;
            if (adc_left == 0) begin
                bus.adc_idle_i = 1'b1;
                bus.adc_data_i = adc_v;
                e.data = 16'd0 - adc_v;
                e.cyc  = n + 2 + LAT;
                sb.push_back(e);
                fstb_cyc = n + 1;
            end else begin
                bus.adc_data_i = 16'($urandom);
            end
        end
        if (bus.adc_start_o) begin
            if (hang_next) begin
                hang_next = 0;
                to_cyc = n + TMO;
            end else begin
                bus.adc_idle_i = 1'b0;
                if (dir_next) begin
                    adc_left = 20; adc_v = 16'h1234; dir_next = 0;
                end else begin
                    adc_left = $urandom_range(adc_min, adc_max);
                    adc_v = 16'($urandom);
                end
            end
        end
        if (n == to_cyc) begin
            set_to = 1;
            free_cyc = n + 1;
        end

        // Filter bank: negates its input, valid exactly LAT cycles after strobe
        bus.filt_data_i = (n == f_cyc) ? f_val : 16'($urandom);
        if (bus.filt_stb_o) begin
            f_val = 16'd0 - bus.filt_in_o;
            f_cyc = n + LAT;
            saw_fstb = 1;
        end

        // Tick acceptance / overrun, clear priority
        ov_set = tick && busy_n;
        if (tick && !busy_n && bus.enable_i) begin
            start_cyc = n + 1;
            free_cyc  = INF;
        end
        bus.clear_i = clear_now || (clear_on_tick && ov_set);
        if (clear_on_tick && ov_set) clear_on_tick = 0;
        clear_now = 0;
        exp_ov  = ov_set ? 1'b1 : (bus.clear_i ? 1'b0 : exp_ov);
        exp_to  = set_to ? 1'b1 : (bus.clear_i ? 1'b0 : exp_to);
        exp_cnt = bus.clear_i ? 16'(inc) : exp_cnt + 16'(inc);
        pcnt    = tick ? 0 : pcnt + 1;
    endtask

    task automatic run(int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        bus.enable_i    = 1'b0;
        bus.clear_i     = 1'b0;
        bus.adc_idle_i  = 1'b1;
        bus.adc_data_i  = '0;
        bus.filt_data_i = '0;
        bus.dac_idle_i  = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        model_reset();
        pcnt = 1;

        // Nominal: first sample directed (0x1234 -> 0xEDCC), then random
        en_cmd = 1; dir_next = 1;
        run(480);

        // Overrun: conversion longer than the period; clear with a dropped tick
        adc_min = 50; adc_max = 50;
        run(100);
        clear_on_tick = 1;
        run(160);
        adc_min = 2; adc_max = 20;
        run(100);

        // ADC never goes busy -> timeout, no DAC start, count unchanged
        hang_next = 1;
        run(250);
        clear_now = 1;
        run(50);

        // Enable dropped during DAC_WAIT: sample completes, no new start
        drop_en_req = 1;
        run(150);
        en_cmd = 1;
        run(100);

        // Asynchronous reset in the middle of FILT_WAIT
        saw_fstb = 0;
        for (int i = 0; i < 100 && !saw_fstb; i++) step();
        if (!saw_fstb) begin
            checks++; errors++;
            $display("FAIL wait_filt_stb cycle %0d: got no strobe within 100 cycles, expected one", cyc);
        end else begin
            step();
            step(1'b1);
        end
        run(200);

        // Drain: everything issued must have reached the DAC
        en_cmd = 0;
        run(100);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
